// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-stage controller and the data memory.
//   mem_addr/mem_data_in : address and store data, held stable for an access
//   mem_rd/mem_wr        : request strobes, held until completion
//   mem_data_out         : load data, valid while mem_done=1
//   mem_done/mem_err     : completion and error status from the memory
// master = controller side, slave = memory side.
interface mem_access_ctrl_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_data_out;
    logic        mem_done;
    logic        mem_err;

    modport master (
        output mem_addr, mem_data_in, mem_rd, mem_wr,
        input  mem_data_out, mem_done, mem_err
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_rd, mem_wr,
        output mem_data_out, mem_done, mem_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues loads/stores from EX/MEM to a multi-cycle
// data memory, stalls the pipeline until completion, and raises a sticky
// error on misaligned/conflicting ops, memory errors or timeouts.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   Addr, WriteData      : effective address and store data from EX/MEM
//   MemRead, MemWrite    : load / store strobes; halt_in suppresses both
//   mem                  : data-memory bus (master side)
//   MemOut               : load result to MEM/WB
//   stall_out            : freeze upstream pipeline this cycle
//   err_out              : sticky error flag
module mem_access_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        Addr,
    input  logic [15:0]        WriteData,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               halt_in,
    mem_access_ctrl_if.master  mem,
    output logic [15:0]        MemOut,
    output logic               stall_out,
    output logic               err_out
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     addr_q;
    logic [15:0]     data_q;
    logic [15:0]     hold_q;
    logic            rd_q;
    logic            wr_q;

    logic            op, bad, issue, busy, active;
    logic            req_rd, req_wr, fail, done, ld_done;
    logic [CW-1:0]   cnt_inc;

    always_comb begin
        op      = (MemRead | MemWrite) & ~halt_in;
        bad     = op & ((MemRead & MemWrite) | Addr[0]);
        // Outputs are combinational so a hit costs no extra cycle; rst gates
        // them so nothing is requested while reset is held.
        issue   = ~rst & (state_q == IDLE) & op & ~bad;
        busy    = ~rst & (state_q == BUSY);
        active  = issue | busy;
        req_rd  = issue ? MemRead  : (busy & rd_q);
        req_wr  = issue ? MemWrite : (busy & wr_q);
        // A memory error outranks completion in the same cycle.
        fail    = active & mem.mem_err;
        done    = active & mem.mem_done & ~mem.mem_err;
        ld_done = done & req_rd;
        cnt_inc = cnt_q + CW'(1);

        mem.mem_rd      = req_rd;
        mem.mem_wr      = req_wr;
        mem.mem_addr    = (state_q == IDLE) ? Addr      : addr_q;
        mem.mem_data_in = (state_q == IDLE) ? WriteData : data_q;

        MemOut    = rst ? 16'h0000 : (ld_done ? mem.mem_data_out : hold_q);
        stall_out = active & ~mem.mem_done & ~mem.mem_err;
        err_out   = ~rst & ((state_q == ERR) | ((state_q == IDLE) & bad) | fail);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            if (ld_done)
                hold_q <= mem.mem_data_out;
            case (state_q)
                IDLE: begin
                    if (bad) begin
                        state_q <= ERR;
                    end else if (issue) begin
                        addr_q <= Addr;
                        data_q <= WriteData;
                        rd_q   <= MemRead;
                        wr_q   <= MemWrite;
                        if (fail) begin
                            state_q <= ERR;
                        end else if (!done) begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (fail) begin
                        state_q <= ERR;
                    end else if (done) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        // Counter stops at TIMEOUT because ERR never counts.
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CW'(TIMEOUT))
                            state_q <= ERR;
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage controller between the EX/MEM pipeline register and the data-memory system; feeds MemOut into the MEM/WB register.
- Issues each load/store to a multi-cycle data memory and holds the address and write data stable for the whole access.
- Stalls the upstream pipeline until the memory reports completion.
- Flags misaligned, conflicting, failed or timed-out accesses as a sticky error.

Parameters:
TIMEOUT, 64, maximum cycles spent in BUSY before the access is declared failed (minimum 2).

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
Addr  in  16  effective address from EX/MEM (ALU result)
WriteData  in  16  store data from EX/MEM
MemRead  in  1  current instruction is a load
MemWrite  in  1  current instruction is a store
halt_in  in  1  current instruction is HALT; suppresses any access
mem_addr  out  16  address to data memory
mem_data_in  out  16  write data to data memory
mem_rd  out  1  read request, held until completion
mem_wr  out  1  write request, held until completion
mem_data_out  in  16  read data from memory, valid when mem_done=1
mem_done  in  1  access complete this cycle
mem_err  in  1  memory-system error
MemOut  out  16  load result to MEM/WB
stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
err_out  out  1  sticky error, forwarded with the instruction to MEM/WB

Behaviour:
Reset and state
- Reset is synchronous and active-high; clk and rst are the only clock and reset.
- After reset: state=IDLE, cycle counter=0, latched addr/data=0, read-hold register=0.
- Also after reset: stall_out=0, err_out=0, mem_rd=0, mem_wr=0, MemOut=0.
- States: IDLE, BUSY, ERR (2-bit encoding).
- An op is present when (MemRead|MemWrite) & !halt_in.

IDLE
- No op present: mem_rd=mem_wr=0, stall_out=0, remain IDLE.
- Invalid op: MemRead&MemWrite=1, or Addr[0]=1 (misaligned). No request is issued, and the block goes to ERR next cycle. err_out rises combinationally in the same cycle.
- Valid op: drive mem_addr=Addr, mem_data_in=WriteData, and mem_rd=MemRead or mem_wr=MemWrite combinationally. Latch Addr, WriteData and the op type.
  - mem_done=1 in the same cycle (hit): zero added latency; stall_out=0; remain IDLE. For a load, MemOut=mem_data_out and the read-hold register captures it.
  - mem_done=0: stall_out=1, go to BUSY, counter set to 1.

BUSY
- Keep driving mem_rd/mem_wr, mem_addr and mem_data_in from the latched copies, ignoring upstream inputs.
- stall_out=1 until the completion cycle.
- On mem_done=1: stall_out=0 that cycle, go to IDLE, clear the counter. For a load, MemOut=mem_data_out and the read-hold register captures it.
- Otherwise the counter increments. If counter reaches TIMEOUT with no done, go to ERR.

mem_err
- mem_err=1 during any cycle with an active request (IDLE issue or BUSY) takes priority over mem_done.
- The block goes to ERR; err_out=1 that cycle.

ERR
- Sticky until rst. err_out=1, stall_out=0, mem_rd=mem_wr=0.
- Upstream continues so the error propagates and halts the machine.

MemOut
- mem_data_out when a load completes this cycle; otherwise the read-hold register value.
- Stores never update the read-hold register.

Boundaries
- rst asserted mid-access (BUSY) aborts the access: request deasserts and IDLE is entered on that edge.
- halt_in with MemRead/MemWrite set: treated as no op.
- A back-to-back valid op in IDLE the cycle after completion is issued immediately (no bubble).
- TIMEOUT counter width is clog2(TIMEOUT+1) bits and does not wrap.

Test Plan:
- Reset: hold rst for 2 cycles with MemRead=1, Addr=16'h0010 -> mem_rd=0, stall_out=0, err_out=0, MemOut=0. After release -> mem_rd=1 in the same cycle.
- Hit load: Addr=16'h0020, MemRead=1, memory returns mem_done=1 with mem_data_out=16'hBEEF in the same cycle -> stall_out=0 throughout, MemOut=16'hBEEF. MemOut stays 16'hBEEF next cycle with no op.
- Miss store: Addr=16'h0100, WriteData=16'h1234, done after 4 cycles; upstream Addr changes to 16'hFFFE in cycle 2 -> mem_wr=1 for 5 cycles, stall_out=1 for 4 cycles then 0. mem_addr stays 16'h0100 and mem_data_in stays 16'h1234 throughout. MemOut unchanged.
- Misaligned: MemRead=1, Addr=16'h0003 -> no mem_rd, err_out=1 the same cycle and every cycle after, until rst.
- Timeout/err: with TIMEOUT=8, a read never completes -> stall_out=1 for 8 cycles, then ERR with stall_out=0, err_out=1. A separate run asserts mem_err together with mem_done in BUSY -> ERR, and the read data is not captured.
- Back-to-back: a load completing (done in cycle 3, data 16'h00AA) followed immediately by a store to 16'h0042 -> mem_wr=1 on the very next cycle, with no idle cycle between the requests.
